// File: rtl/data_mem_bank_pkg.sv
// rtl/data_mem_bank_pkg.sv - shared types and constants for the data memory bank
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_mem_bank_if.sv
// rtl/data_mem_bank_if.sv - request/response and clear bus between load/store unit and memory bank
interface data_mem_bank_if
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);

    logic                       clr_req;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic [lanes(DATA_W)-1:0]   req_be;
    logic                       rsp_valid;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic                       busy;

    modport master (
        output clr_req, req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  clr_req, req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/data_mem_bank_rsp_pipe.sv
// rtl/data_mem_bank_rsp_pipe.sv - RD_LAT-deep response pipeline carrying {valid, err, rdata}
module mem_rsp_pipe #(
    parameter int RD_LAT = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic              in_err_i,
    input  logic [DATA_W-1:0] in_rdata_i,
    output logic              out_valid_o,
    output logic              out_err_o,
    output logic [DATA_W-1:0] out_rdata_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload is not reset; the output masks it with valid so idle outputs read as zero.
    always_ff @(posedge clk) begin
        err_q[0]  <= in_err_i;
        data_q[0] <= in_rdata_i;
        for (int i = 1; i < RD_LAT; i++) begin
            err_q[i]  <= err_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid_o = valid_q[RD_LAT-1];
    assign out_err_o   = valid_q[RD_LAT-1] & err_q[RD_LAT-1];
    assign out_rdata_o = valid_q[RD_LAT-1] ? data_q[RD_LAT-1] : '0;

endmodule

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - parametrised single-port data memory with byte enables and clear engine
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_bank_if.slave bus
);

    localparam int                LANES     = lanes(DATA_W);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    generate
        if ((DATA_W % 8) != 0) begin : g_bad_data_w
            $error("data_mem_bank: DATA_W must be a multiple of 8");
        end
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("data_mem_bank: RD_LAT must be 1 or 2");
        end
    endgenerate

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              accept;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    assign in_range      = {1'b0, bus.req_addr} < DEPTH_X;
    assign accept        = bus.req_valid && (state_q == READY);
    assign bus.req_ready = (state_q == READY);
    assign bus.busy      = (state_q == CLEAR);
    assign rd_word       = (accept && !bus.req_we && in_range) ? mem_q[bus.req_addr] : '0;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = READY;
                    clr_ptr_d = '0;
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // A request accepted alongside clr_req still writes here; the clear begins next edge.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (accept && bus.req_we && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.req_be[i]) begin
                    mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    mem_rsp_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (accept),
        .in_err_i    (!in_range),
        .in_rdata_i  (rd_word),
        .out_valid_o (bus.rsp_valid),
        .out_err_o   (bus.rsp_err),
        .out_rdata_o (bus.rsp_rdata)
    );

endmodule
